// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot and periodic modes.
// Raises a one-cycle done pulse when the count runs out.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] rld;
  logic             mode;

  // Timer FSM: load > stop > start > count, done pulses for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= ZERO;
      rld   <= ZERO;
      mode  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rld   <= d;
        q     <= d;
        state <= IDLE;
      end else if (stop) begin
        if (state == RUN)
          state <= IDLE;
      end else if (start && state == IDLE) begin
        if (q != ZERO) begin
          mode  <= periodic;
          state <= RUN;
        end
      end else if (start && state == EXPIRED) begin
        if (rld != ZERO) begin
          q     <= rld;
          mode  <= periodic;
          state <= RUN;
        end
      end else if (state == RUN && en) begin
        if (q > ONE) begin
          q <= q - ONE;
        end else if (q == ONE) begin
          done <= 1'b1;
          if (mode) begin
            q <= rld;
          end else begin
            q     <= ZERO;
            state <= EXPIRED;
          end
        end
      end
    end
  end

  // Status flags decode straight from the state register
  always_comb begin
    busy    = (state == RUN);
    expired = (state == EXPIRED);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer.
// Each scenario queues stimulus and expected outputs per cycle.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, stop, periodic, en;
  logic [3:0] d;
  logic [3:0] q;
  logic       busy, expired, done;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [3:0] dv;
    logic       st;
    logic       sp;
    logic       per;
    logic       en;
  } stim_t;

  typedef struct packed {
    logic [3:0] q;
    logic       b;
    logic       x;
    logic       dn;
  } exp_t;

  stim_t stq[$];
  exp_t  sb[$];

  countdown_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .d(d), .load(load),
    .start(start), .stop(stop), .periodic(periodic),
    .en(en), .q(q), .busy(busy), .expired(expired),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic stim_t s(logic rst, logic ld,
      logic [3:0] dv, logic st, logic sp, logic per,
      logic e);
    return '{rst, ld, dv, st, sp, per, e};
  endfunction

  function automatic exp_t x(logic [3:0] qv, logic b,
      logic xp, logic dn);
    return '{qv, b, xp, dn};
  endfunction

  // queue one cycle: stimulus plus expected state after the edge
  task automatic cyc(stim_t st, exp_t ex);
    stq.push_back(st);
    sb.push_back(ex);
  endtask

  task automatic apply(stim_t st);
    reset    = st.rst;
    load     = st.ld;
    d        = st.dv;
    start    = st.st;
    stop     = st.sp;
    periodic = st.per;
    en       = st.en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t obs();
    return '{q, busy, expired, done};
  endfunction

  task automatic test_reset();
    exp_t o, e;
    int n = 0;
    cyc(s(1,0,4'd9,1,0,1,1), x(0,0,0,0));
    cyc(s(1,0,0,0,0,0,1), x(0,0,0,0));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_oneshot();
    exp_t o, e;
    int n = 0;
    cyc(s(0,1,4'd5,0,0,0,1), x(5,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(5,1,0,0));
    for (int i = 4; i >= 1; i--)
      cyc(s(0,0,0,0,0,0,1), x(4'(i),1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,1));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,0));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL oneshot c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_periodic();
    exp_t o, e;
    int n = 0;
    int qm;
    cyc(s(0,1,4'd3,0,0,0,1), x(3,0,0,0));
    cyc(s(0,0,0,1,0,1,1), x(3,1,0,0));
    qm = 3;
    for (int k = 1; k <= 10; k++) begin
      qm = (qm == 1) ? 3 : qm - 1;
      cyc(s(0,0,0,0,0,0,1), x(4'(qm),1,0,(k % 3) == 0));
    end
    cyc(s(0,0,0,0,1,0,1), x(4'(qm),0,0,0));
    // R=1 periodic: done on every enabled cycle
    cyc(s(0,1,4'd1,0,0,0,1), x(1,0,0,0));
    cyc(s(0,0,0,1,0,1,1), x(1,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,1));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,1));
    cyc(s(0,0,0,0,0,0,0), x(1,1,0,0));
    cyc(s(0,0,0,0,1,0,1), x(1,0,0,0));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL periodic c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_enable();
    exp_t o, e;
    int n = 0;
    int qm = 6;
    cyc(s(0,1,4'd6,0,0,0,1), x(6,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(6,1,0,0));
    for (int k = 1; k <= 11; k++) begin
      if (k % 2 == 1) qm--;
      if (k < 11)
        cyc(s(0,0,0,0,0,0,k % 2 == 1), x(4'(qm),1,0,0));
      else
        cyc(s(0,0,0,0,0,0,1), x(0,0,1,1));
    end
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL enable c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_stop();
    exp_t o, e;
    int n = 0;
    cyc(s(0,1,4'd8,0,0,0,1), x(8,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(8,1,0,0));
    for (int i = 7; i >= 4; i--)
      cyc(s(0,0,0,0,0,0,1), x(4'(i),1,0,0));
    // stop beats a simultaneous start
    cyc(s(0,0,0,1,1,0,1), x(4,0,0,0));
    for (int i = 0; i < 5; i++)
      cyc(s(0,0,0,0,0,0,1), x(4,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(4,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(3,1,0,0));
    cyc(s(0,0,0,1,0,1,1), x(2,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,1));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL stop c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_corners();
    exp_t o, e;
    int n = 0;
    cyc(s(0,1,4'd0,0,0,0,1), x(0,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(0,0,0,0));
    cyc(s(0,1,4'd2,1,0,0,1), x(2,0,0,0));
    cyc(s(0,0,0,0,0,0,1), x(2,0,0,0));
    cyc(s(0,0,0,1,0,0,1), x(2,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,1));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,0));
    cyc(s(0,0,0,1,0,0,1), x(2,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,1,1));
    // back to back: restart from EXPIRED, then load on terminal edge
    cyc(s(0,0,0,1,0,0,1), x(2,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(1,1,0,0));
    cyc(s(0,1,4'd7,0,0,0,1), x(7,0,0,0));
    cyc(s(0,0,0,0,0,0,1), x(7,0,0,0));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL corner c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  task automatic test_reset_midrun();
    exp_t o, e;
    int n = 0;
    cyc(s(0,1,4'd5,0,0,0,1), x(5,0,0,0));
    cyc(s(0,0,0,1,0,1,1), x(5,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(4,1,0,0));
    cyc(s(0,0,0,0,0,0,1), x(3,1,0,0));
    cyc(s(1,0,0,0,0,0,1), x(0,0,0,0));
    cyc(s(0,0,0,1,0,1,1), x(0,0,0,0));
    cyc(s(0,0,0,0,0,0,1), x(0,0,0,0));
    while (stq.size() > 0) begin
      apply(stq.pop_front());
      tick();
      o = obs();
      e = sb.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL rstrun c%0d got q=%0d b=%b x=%b d=%b want q=%0d b=%b x=%b d=%b",
          n, o.q, o.b, o.x, o.dn, e.q, e.b, e.x, e.dn);
      end
      n++;
    end
  endtask

  initial begin
    apply(s(1,0,0,0,0,0,0));
    test_reset();
    test_oneshot();
    test_periodic();
    test_enable();
    test_stop();
    test_corners();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
